// File: rtl/assist_sequencer.sv
// Motor-assist sequencer: heart-rate PI loop, safety gating (tilt, brake, stall)
// and slew-limited PWM command toward the computed target.
module assist_sequencer #(
    parameter int unsigned KP              = 16,
    parameter int unsigned KI              = 2,
    parameter int unsigned SHIFT           = 4,
    parameter int unsigned INT_LIMIT       = 4096,
    parameter int unsigned PWM_MAX         = 511,
    parameter int unsigned TILT_LIMIT      = 45,
    parameter int unsigned RAMP_STEP       = 4,
    parameter int unsigned RAMP_DIV        = 8,
    parameter int unsigned CADENCE_TIMEOUT = 50_000_000,
    parameter int unsigned DROPOUT_CYCLES  = 150_000_000
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic [7:0]        heart_rate_i,
    input  logic              heart_rate_valid_i,
    input  logic [7:0]        heart_rate_set_point_i,
    input  logic signed [9:0] resolved_roll_i,
    input  logic signed [9:0] resolved_pitch_i,
    input  logic              cadence_i,
    input  logic              brake_i,
    input  logic              fault_clear_i,
    output logic signed [9:0] pwm_out_o,
    output logic              fault_o,
    output logic              update_done_o,
    output logic [2:0]        state_o
);

    // state  | meaning
    // IDLE   | assist off, target/integral cleared, PWM ramps to 0
    // ASSIST | PI loop active, PWM ramps toward target
    // STALL  | cadence or heart-rate dropout timeout, like IDLE
    // BRAKE  | brake held, PWM forced to 0, integral held
    // FAULT  | tilt fault latched, PWM forced to 0, integral cleared
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ASSIST = 3'd1,
        ST_STALL  = 3'd2,
        ST_BRAKE  = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    localparam int CAD_W  = $clog2(CADENCE_TIMEOUT + 1);
    localparam int DROP_W = $clog2(DROPOUT_CYCLES + 1);
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [CAD_W-1:0]    CAD_MAX   = CAD_W'(CADENCE_TIMEOUT);
    localparam logic [DROP_W-1:0]   DROP_MAX  = DROP_W'(DROPOUT_CYCLES);
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [9:0]          TILT_LIM  = 10'(TILT_LIMIT);
    localparam logic [9:0]          PWM_LIM   = 10'(PWM_MAX);
    localparam logic [9:0]          STEP      = 10'(RAMP_STEP);
    localparam logic signed [16:0]  INT_HI    = 17'(INT_LIMIT);
    localparam logic signed [16:0]  INT_LO    = -INT_HI;
    localparam logic signed [25:0]  KP_S      = 26'(KP);
    localparam logic signed [25:0]  KI_S      = 26'(KI);
    localparam logic signed [25:0]  PWM_S     = 26'(PWM_MAX);

    state_e                state_q, state_d;
    logic [2:0]            cad_sync_q, cad_sync_d;
    logic [CAD_W-1:0]      cad_cnt_q, cad_cnt_d;
    logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic [RAMP_W-1:0]     ramp_cnt_q, ramp_cnt_d;
    logic                  s1_q, s1_d, s2_q, s2_d;
    logic signed [8:0]     err_q, err_d;
    logic signed [15:0]    integral_q, integral_d;
    logic [9:0]            target_q, target_d;
    logic [9:0]            pwm_q, pwm_d;
    logic                  update_done_q, update_done_d;

    logic                  cad_rise, stall, tilt, stay, ramp_tick, windup_block, quiet;
    logic [9:0]            roll_abs, pitch_abs, ramp_target, diff;
    logic signed [16:0]    int_sum;
    logic signed [25:0]    sum_c, shifted;
    logic [9:0]            clamped;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            cad_sync_q    <= '0;
            cad_cnt_q     <= '0;
            drop_cnt_q    <= '0;
            ramp_cnt_q    <= '0;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            err_q         <= '0;
            integral_q    <= '0;
            target_q      <= '0;
            pwm_q         <= '0;
            update_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cad_sync_q    <= cad_sync_d;
            cad_cnt_q     <= cad_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            ramp_cnt_q    <= ramp_cnt_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            err_q         <= err_d;
            integral_q    <= integral_d;
            target_q      <= target_d;
            pwm_q         <= pwm_d;
            update_done_q <= update_done_d;
        end
    end

    // Unsigned negate so that -512 maps to 512 rather than overflowing.
    assign roll_abs  = resolved_roll_i[9]  ? (~resolved_roll_i  + 10'd1) : resolved_roll_i;
    assign pitch_abs = resolved_pitch_i[9] ? (~resolved_pitch_i + 10'd1) : resolved_pitch_i;
    assign tilt      = (roll_abs > TILT_LIM) || (pitch_abs > TILT_LIM);
    assign cad_rise  = cad_sync_q[1] & ~cad_sync_q[2];
    assign stall     = (cad_cnt_q == CAD_MAX) || (drop_cnt_q == DROP_MAX);

    always_comb begin
        state_d = state_q;
        if (tilt) begin
            state_d = ST_FAULT;
        end else if (state_q == ST_FAULT) begin
            if (fault_clear_i) state_d = ST_IDLE;
        end else if (brake_i) begin
            state_d = ST_BRAKE;
        end else if (state_q == ST_BRAKE) begin
            state_d = ST_IDLE;
        end else if (!enable_i) begin
            state_d = ST_IDLE;
        end else if (stall) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_ASSIST;
        end
    end

    always_comb begin
        cad_sync_d    = {cad_sync_q[1:0], cadence_i};
        cad_cnt_d     = cad_rise ? '0 : ((cad_cnt_q == CAD_MAX) ? cad_cnt_q : cad_cnt_q + 1'b1);
        drop_cnt_d    = heart_rate_valid_i ? '0 :
                        ((drop_cnt_q == DROP_MAX) ? drop_cnt_q : drop_cnt_q + 1'b1);
        ramp_tick     = (ramp_cnt_q == RAMP_LAST);
        ramp_cnt_d    = ramp_tick ? '0 : ramp_cnt_q + 1'b1;

        // Pipeline only advances while ASSIST holds across the edge; any exit aborts it.
        stay          = (state_q == ST_ASSIST) && (state_d == ST_ASSIST);
        quiet         = (state_q == ST_IDLE) || (state_q == ST_STALL) || (state_q == ST_FAULT);
        s1_d          = heart_rate_valid_i && stay && !s1_q && !s2_q;
        s2_d          = s1_q && stay;
        err_d         = err_q;
        if (s1_d) begin
            err_d = $signed({1'b0, heart_rate_set_point_i}) - $signed({1'b0, heart_rate_i});
        end

        int_sum       = {integral_q[15], integral_q} + {{8{err_q[8]}}, err_q};
        windup_block  = ((target_q == PWM_LIM) && !err_q[8] && (err_q != 9'sd0)) ||
                        ((target_q == 10'd0) && err_q[8]);
        integral_d    = integral_q;
        if (quiet) begin
            integral_d = '0;
        end else if (s1_q && stay && !windup_block) begin
            if (int_sum > INT_HI)      integral_d = INT_HI[15:0];
            else if (int_sum < INT_LO) integral_d = INT_LO[15:0];
            else                       integral_d = int_sum[15:0];
        end

        sum_c         = KP_S * {{17{err_q[8]}}, err_q} + KI_S * {{10{integral_q[15]}}, integral_q};
        shifted       = sum_c >>> SHIFT;
        if (shifted[25])          clamped = 10'd0;
        else if (shifted > PWM_S) clamped = PWM_LIM;
        else                      clamped = shifted[9:0];

        target_d      = target_q;
        update_done_d = 1'b0;
        if (quiet) begin
            target_d = '0;
        end else if (s2_q && stay) begin
            target_d      = clamped;
            update_done_d = 1'b1;
        end

        // IDLE/STALL ramp toward 0 immediately, even before the stored target clears.
        ramp_target   = (state_q == ST_ASSIST) ? target_q : 10'd0;
        diff          = (pwm_q > ramp_target) ? (pwm_q - ramp_target) : (ramp_target - pwm_q);
        pwm_d         = pwm_q;
        if ((state_d == ST_BRAKE) || (state_d == ST_FAULT)) begin
            pwm_d = '0;
        end else if (ramp_tick && (state_q != ST_BRAKE) && (state_q != ST_FAULT)) begin
            if (pwm_q < ramp_target)      pwm_d = pwm_q + ((diff > STEP) ? STEP : diff);
            else if (pwm_q > ramp_target) pwm_d = pwm_q - ((diff > STEP) ? STEP : diff);
        end
    end

    assign pwm_out_o     = pwm_q;
    assign fault_o       = (state_q == ST_FAULT);
    assign update_done_o = update_done_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_assist_sequencer.sv
// Directed bench for assist_sequencer: PI target, ramp, clamp/anti-windup,
// brake, tilt fault, cadence stall and reset abort.
module tb_assist_sequencer;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [7:0]        hr;
    logic              hr_valid;
    logic [7:0]        sp;
    logic signed [9:0] roll;
    logic signed [9:0] pitch;
    logic              cadence;
    logic              brake;
    logic              fault_clear;
    logic signed [9:0] pwm;
    logic              fault;
    logic              done;
    logic [2:0]        state;
    logic              cad_en;

    int n_checks = 0;
    int n_errors = 0;

    assist_sequencer #(
        .CADENCE_TIMEOUT (100),
        .DROPOUT_CYCLES  (5000)
    ) dut (
        .clk_i                  (clk),
        .reset_n_i              (reset_n),
        .enable_i               (enable),
        .heart_rate_i           (hr),
        .heart_rate_valid_i     (hr_valid),
        .heart_rate_set_point_i (sp),
        .resolved_roll_i        (roll),
        .resolved_pitch_i       (pitch),
        .cadence_i              (cadence),
        .brake_i                (brake),
        .fault_clear_i          (fault_clear),
        .pwm_out_o              (pwm),
        .fault_o                (fault),
        .update_done_o          (done),
        .state_o                (state)
    );

    always #5 clk = ~clk;

    initial begin
        cadence = 1'b0;
        forever begin
            #100;
            if (cad_en) cadence = ~cadence;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] h, input logic [7:0] s);
        hr = h;
        sp = s;
        hr_valid = 1'b1;
        @(negedge clk);
        hr_valid = 1'b0;
    endtask

    int exp_ramp [6] = '{4, 8, 12, 16, 20, 22};
    int k;
    int cnt;
    logic [9:0] last;

    initial begin
        reset_n = 1'b0; enable = 1'b1; hr = '0; hr_valid = 1'b0; sp = '0;
        roll = '0; pitch = '0; brake = 1'b0; fault_clear = 1'b0; cad_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pwm",   $unsigned(pwm), 0);
        chk("rst_state", state, 0);
        chk("rst_fault", fault, 0);
        chk("rst_done",  done, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_to_assist", state, 1);

        // HR=120, SP=140 -> err=20, integral=20, sum=360, target=22
        strobe(8'd120, 8'd140);
        chk("done_lat1", done, 0);
        @(negedge clk);
        chk("done_lat2", done, 0);
        @(negedge clk);
        chk("done_lat3", done, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        k = 0;
        last = '0;
        for (int i = 0; i < 100 && k < 6; i++) begin
            @(negedge clk);
            if (pwm != last) begin
                chk($sformatf("ramp_step%0d", k), $unsigned(pwm), exp_ramp[k]);
                last = pwm;
                k++;
            end
        end
        chk("ramp_count", k, 6);
        repeat (20) @(negedge clk);
        chk("ramp_hold", $unsigned(pwm), 22);

        // err=140 repeatedly: integral 160,300,..,3100 then frozen by anti-windup at 511
        for (int i = 0; i < 30; i++) begin
            strobe(8'd60, 8'd200);
            repeat (9) @(negedge clk);
        end
        repeat (1100) @(negedge clk);
        chk("clamp_511", $unsigned(pwm), 511);
        // err=0 exposes the frozen integral: 2*3100>>>4 = 387
        strobe(8'd150, 8'd150);
        repeat (300) @(negedge clk);
        chk("antiwindup_387", $unsigned(pwm), 387);

        roll = 10'sd45; pitch = -10'sd45;
        @(negedge clk);
        chk("tilt_edge45", state, 1);
        roll = '0; pitch = '0;

        brake = 1'b1;
        @(negedge clk);
        chk("brake_pwm0",  $unsigned(pwm), 0);
        chk("brake_state", state, 3);
        brake = 1'b0;
        @(negedge clk);
        chk("brake_rel_idle", state, 0);
        @(negedge clk);
        chk("brake_rel_assist", state, 1);

        roll = 10'sd46;
        @(negedge clk);
        chk("tilt_state", state, 4);
        chk("tilt_pwm0",  $unsigned(pwm), 0);
        chk("tilt_fault", fault, 1);
        fault_clear = 1'b1;
        @(negedge clk);
        chk("clear_ignored", state, 4);
        roll = 10'sd10;
        @(negedge clk);
        chk("clear_idle", state, 0);
        chk("clear_fault", fault, 0);
        fault_clear = 1'b0;
        @(negedge clk);
        chk("clear_assist", state, 1);
        pitch = -10'sd46;
        @(negedge clk);
        chk("pitch_neg_fault", state, 4);
        pitch = '0; fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        @(negedge clk);
        chk("pitch_recover", state, 1);

        // integral cleared by FAULT/IDLE, so target is 22 again
        strobe(8'd120, 8'd140);
        repeat (80) @(negedge clk);
        chk("post_fault_22", $unsigned(pwm), 22);

        cad_en = 1'b0;
        cnt = 0;
        while (state != 3'd2 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("stall_enter", state, 2);
        repeat (80) @(negedge clk);
        chk("stall_pwm0", $unsigned(pwm), 0);
        cad_en = 1'b1;
        cnt = 0;
        while (state != 3'd1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("stall_resume", state, 1);

        // a held integral would give 25 here instead of 22
        strobe(8'd120, 8'd140);
        repeat (80) @(negedge clk);
        chk("stall_int_cleared", $unsigned(pwm), 22);

        hr = 8'd60; sp = 8'd200; hr_valid = 1'b1;
        @(negedge clk);
        hr_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_pwm",   $unsigned(pwm), 0);
        chk("midrst_state", state, 0);
        chk("midrst_done",  done, 0);
        chk("midrst_fault", fault, 0);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
